// File: rtl/macro_vector_sequencer_pkg.sv
// Shared types, state encoding and the default operand table for the macro vector sequencer.
// VAR_1 / VAR_2 fall back to 2 / 5 unless the build defines them.
`ifndef VAR_1
`define VAR_1 2
`endif
`ifndef VAR_2
`define VAR_2 5
`endif

package macro_seq_pkg;

  localparam int VEC_DATA_W = 32;
  localparam int VEC_COUNT  = 4;

  typedef struct packed {
    logic [VEC_DATA_W-1:0] a;
    logic [VEC_DATA_W-1:0] b;
    logic [VEC_DATA_W:0]   expected;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Index 0 sits in the least significant slot of the packed table.
  localparam vec_t [VEC_COUNT-1:0] VECTORS = {
    vec_t'{32'd10, 32'd20, 33'd30},
    vec_t'{32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000},
    vec_t'{32'd0, 32'd0, 33'd0},
    vec_t'{32'(`VAR_1), 32'(`VAR_2), 33'd7}
  };

  function automatic logic sum_matches(input logic [VEC_DATA_W:0] sum, input vec_t v);
    return (sum == v.expected);
  endfunction

endpackage

// File: rtl/macro_vector_sequencer_add_unit.sv
// Pipelined adder with a carry-out bit; accepts a new operand pair only when the pipe is empty.
module macro_add_unit #(
  parameter int DATA_W  = 32,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W:0]   sum
);

  logic [ADD_LAT-1:0] valid_q, valid_d;
  logic [DATA_W:0]    data_q [ADD_LAT];
  logic [DATA_W:0]    data_d [ADD_LAT];

  assign in_ready  = ~(|valid_q);
  assign out_valid = valid_q[ADD_LAT-1];
  assign sum       = data_q[ADD_LAT-1];

  // Stage 0 captures the widened sum; later stages shift it toward the output.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid && in_ready;
    data_d[0]  = {1'b0, a} + {1'b0, b};
    for (int i = 1; i < ADD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Valid bits are flushed by reset so no stale result survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    data_q <= data_d;
  end

endmodule

// File: rtl/macro_vector_sequencer.sv
// Walks the operand table through the shared adder, counts matches and latches the first mismatch.
module macro_vector_sequencer
  import macro_seq_pkg::*;
#(
  parameter int NUM_VECTORS = VEC_COUNT,
  parameter int DATA_W      = VEC_DATA_W,
  parameter int ADD_LAT     = 1,
  parameter vec_t [NUM_VECTORS-1:0] VECTOR_TABLE = VECTORS,
  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  localparam int CNT_W = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ERROR,
  output logic [IDX_W-1:0] fail_idx,
  output logic [CNT_W-1:0] pass_count
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [DATA_W:0]  sum_q, sum_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  vec_t            cur_vec;
  logic            add_in_valid, add_in_ready, add_out_valid;
  logic [DATA_W:0] add_sum;

  assign cur_vec      = VECTOR_TABLE[idx_q];
  assign add_in_valid = (state_q == S_ISSUE);

  macro_add_unit #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT)) u_add (
    .clk      (clk),
    .rst      (rst),
    .in_valid (add_in_valid),
    .in_ready (add_in_ready),
    .a        (cur_vec.a),
    .b        (cur_vec.b),
    .out_valid(add_out_valid),
    .sum      (add_sum)
  );

  // Next-state and result bookkeeping; busy/done follow the state one cycle later.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    sum_d      = sum_q;
    error_d    = error_q;
    busy_d     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    done_d     = (state_q == S_DONE) && !start;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (add_in_valid && add_in_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (add_out_valid) begin
          sum_d   = add_sum;
          state_d = S_CHECK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CHECK: begin
        if (sum_matches(sum_q, cur_vec)) begin
          pass_d = pass_q + CNT_W'(1);
        end else if (!error_q) begin
          error_d    = 1'b1;
          fail_idx_d = idx_q;
        end else begin
          error_d = error_q;
        end
        if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_ISSUE;
          idx_d      = '0;
          error_d    = 1'b0;
          fail_idx_d = '0;
          pass_d     = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      fail_idx_q <= '0;
      pass_q     <= '0;
      sum_q      <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
      sum_q      <= sum_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ERROR      = error_q;
  assign fail_idx   = fail_idx_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_macro_vector_sequencer.sv
// Bench for macro_vector_sequencer: four instances (three tables, two latencies) checked each cycle
// against a timing model derived from start/reset edges, plus hand-computed literal expectations.
`ifndef VAR_1
`define VAR_1 2
`endif
`ifndef VAR_2
`define VAR_2 5
`endif

module tb_macro_vector_sequencer;
  import macro_seq_pkg::*;

  localparam vec_t [3:0] TBL_DEF = {
    vec_t'{32'd10, 32'd20, 33'd30},
    vec_t'{32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000},
    vec_t'{32'd0, 32'd0, 33'd0},
    vec_t'{32'(`VAR_1), 32'(`VAR_2), 33'd7}
  };
  localparam vec_t [3:0] TBL_BAD3 = {
    vec_t'{32'd10, 32'd20, 33'd31},
    vec_t'{32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000},
    vec_t'{32'd0, 32'd0, 33'd0},
    vec_t'{32'(`VAR_1), 32'(`VAR_2), 33'd7}
  };
  localparam vec_t [3:0] TBL_BAD12 = {
    vec_t'{32'd10, 32'd20, 33'd30},
    vec_t'{32'hFFFF_FFFF, 32'd1, 33'h0_0000_0000},
    vec_t'{32'd0, 32'd0, 33'd1},
    vec_t'{32'(`VAR_1), 32'(`VAR_2), 33'd7}
  };
  localparam int LAT [4] = '{1, 1, 1, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy_o [4];
  logic       done_o [4];
  logic       err_o  [4];
  logic [1:0] fidx_o [4];
  logic [2:0] pass_o [4];

  int   n_vec = 0;
  int   n_err = 0;
  int   edge_no = 0;
  bit   mvalid = 1'b0;
  bit   run_on [4];
  int   run_s  [4];
  int   done_edge [4];
  logic [3:0] mask [4];

  always #5 clk = ~clk;

  macro_vector_sequencer #(.ADD_LAT(1), .VECTOR_TABLE(TBL_DEF)) u_def (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[0]), .done(done_o[0]),
    .ERROR(err_o[0]), .fail_idx(fidx_o[0]), .pass_count(pass_o[0]));
  macro_vector_sequencer #(.ADD_LAT(1), .VECTOR_TABLE(TBL_BAD3)) u_bad3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[1]), .done(done_o[1]),
    .ERROR(err_o[1]), .fail_idx(fidx_o[1]), .pass_count(pass_o[1]));
  macro_vector_sequencer #(.ADD_LAT(1), .VECTOR_TABLE(TBL_BAD12)) u_bad12 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[2]), .done(done_o[2]),
    .ERROR(err_o[2]), .fail_idx(fidx_o[2]), .pass_count(pass_o[2]));
  macro_vector_sequencer #(.ADD_LAT(3), .VECTOR_TABLE(TBL_DEF)) u_lat3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_o[3]), .done(done_o[3]),
    .ERROR(err_o[3]), .fail_idx(fidx_o[3]), .pass_count(pass_o[3]));

  function automatic logic [3:0] pass_mask(input vec_t [3:0] t);
    logic [3:0] m;
    for (int j = 0; j < 4; j++) begin
      m[j] = (({1'b0, t[j].a} + {1'b0, t[j].b}) == t[j].expected);
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic goto_edge(input int e);
    while (edge_no < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a run begins on an accepted start edge; every vector costs LAT+2 cycles.
  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        run_on[k] <= 1'b0;
        mvalid    <= 1'b1;
      end else if (start && (!run_on[k] || (edge_no + 1 - run_s[k]) > 4 * (LAT[k] + 2))) begin
        run_on[k] <= 1'b1;
        run_s[k]  <= edge_no + 1;
      end
    end
  end

  // Compare every output of every instance against the model once per cycle.
  always @(negedge clk) begin
    int d, p, c, pc, fi;
    logic eb, ed, er;
    if (mvalid) begin
      for (int k = 0; k < 4; k++) begin
        eb = 1'b0; ed = 1'b0; er = 1'b0; pc = 0; fi = 0;
        if (run_on[k]) begin
          d = edge_no - run_s[k];
          p = LAT[k] + 2;
          c = d / p;
          if (c > 4) c = 4;
          eb = (d >= 1) && (d <= 4 * p);
          ed = (d > 4 * p);
          for (int j = 0; j < c; j++) begin
            if (mask[k][j]) pc++;
            else if (!er) begin er = 1'b1; fi = j; end
          end
        end
        chk($sformatf("u%0d busy", k), 32'(busy_o[k]), 32'(eb));
        chk($sformatf("u%0d done", k), 32'(done_o[k]), 32'(ed));
        chk($sformatf("u%0d ERROR", k), 32'(err_o[k]), 32'(er));
        chk($sformatf("u%0d fail_idx", k), 32'(fidx_o[k]), 32'(fi));
        chk($sformatf("u%0d pass_count", k), 32'(pass_o[k]), 32'(pc));
        if (done_o[k] === 1'b1 && done_edge[k] == 0) done_edge[k] = edge_no;
      end
    end
  end

  initial begin
    mask[0] = pass_mask(TBL_DEF);
    mask[1] = pass_mask(TBL_BAD3);
    mask[2] = pass_mask(TBL_BAD12);
    mask[3] = pass_mask(TBL_DEF);
    for (int k = 0; k < 4; k++) done_edge[k] = 0;

    goto_edge(2);
    rst = 1'b0;
    goto_edge(8);
    chk("idle busy", 32'(busy_o[0]), 32'd0);
    chk("idle done", 32'(done_o[0]), 32'd0);

    goto_edge(9);
    start = 1'b1;
    goto_edge(10);
    start = 1'b0;
    goto_edge(14);
    start = 1'b1;
    goto_edge(15);
    start = 1'b0;

    goto_edge(35);
    chk("pin def done edge", 32'(done_edge[0]), 32'd23);
    chk("pin lat3 done edge", 32'(done_edge[3]), 32'd31);
    chk("pin def pass", 32'(pass_o[0]), 32'd4);
    chk("pin def ERROR", 32'(err_o[0]), 32'd0);
    chk("pin bad3 ERROR", 32'(err_o[1]), 32'd1);
    chk("pin bad3 fail_idx", 32'(fidx_o[1]), 32'd3);
    chk("pin bad3 pass", 32'(pass_o[1]), 32'd3);
    chk("pin bad12 fail_idx", 32'(fidx_o[2]), 32'd1);
    chk("pin bad12 pass", 32'(pass_o[2]), 32'd2);
    chk("pin lat3 pass", 32'(pass_o[3]), 32'd4);

    goto_edge(39);
    start = 1'b1;
    goto_edge(40);
    start = 1'b0;
    chk("pin restart ERROR", 32'(err_o[1]), 32'd0);
    chk("pin restart pass", 32'(pass_o[1]), 32'd0);
    chk("pin restart done", 32'(done_o[1]), 32'd0);

    goto_edge(44);
    rst = 1'b1;
    goto_edge(45);
    rst = 1'b0;
    chk("pin rst busy", 32'(busy_o[0]), 32'd0);
    chk("pin rst pass", 32'(pass_o[0]), 32'd0);

    goto_edge(49);
    start = 1'b1;
    goto_edge(50);
    start = 1'b0;
    goto_edge(75);
    chk("pin rerun def pass", 32'(pass_o[0]), 32'd4);
    chk("pin rerun def done", 32'(done_o[0]), 32'd1);
    chk("pin rerun lat3 pass", 32'(pass_o[3]), 32'd4);
    chk("pin rerun bad12 fail_idx", 32'(fidx_o[2]), 32'd1);

    goto_edge(77);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
